lcd_sequencer: RTL and testbench

//  Front-end scheduler for the LCD write engine (command register + wait counter + address walker + E strobe).

---
 rtl/lcd_sequencer_pkg.sv | 39 +++
 rtl/lcd_sequencer_rr_arbiter.sv | 27 ++
 rtl/lcd_sequencer.sv | 155 +++++++++++++++
 tb/tb_lcd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_sequencer_pkg.sv
// Shared constants for the LCD front-end sequencer: engine commands, FSM states
// and the power-up wait computation.
package lcd_sequencer_pkg;

    localparam logic [10:0] CMD_FUNC_SET   = 11'h038;
    localparam logic [10:0] CMD_DISPLAY_ON = 11'h00C;
    localparam logic [10:0] CMD_CLEAR      = 11'h001;
    localparam logic [10:0] CMD_ENTRY_MODE = 11'h006;
    localparam logic [10:0] CMD_WRITE_DATA = 11'h200;
    localparam logic [1:0]  INIT_LAST      = 2'd3;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT_ISSUE,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_GRANT,
        ST_RUN
    } state_t;

    function automatic logic [10:0] init_cmd(input logic [1:0] idx);
        logic [10:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISPLAY_ON;
            2'd2:    cmd = CMD_CLEAR;
            default: cmd = CMD_ENTRY_MODE;
        endcase
        return cmd;
    endfunction

    // 15 ms of clock cycles, rounded up, never less than one cycle.
    function automatic int pwr_tact(input int clock_hz);
        longint t;
        t = (longint'(clock_hz) * 15 + 999) / 1000;
        return (t < 1) ? 1 : int'(t);
    endfunction

endpackage

// File: rtl/lcd_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer,
// returned both one-hot and as an index.
module lcd_sequencer_rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % N_REQ]) begin
                found = 1'b1;
                grant[(int'(ptr) + i) % N_REQ] = 1'b1;
                grant_idx = ($clog2(N_REQ))'((int'(ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/lcd_sequencer.sv
// LCD write-engine front end: power-up wait, init command list, then round-robin
// sharing of the engine between requesters, with a stall watchdog forcing re-init.
module lcd_sequencer
    import lcd_sequencer_pkg::*;
#(
    parameter int CLOCK     = 2614,
    parameter int WIDTH_MEM = 4,
    parameter int N_REQ     = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*WIDTH_MEM-1:0] i_addr_begin,
    input  logic [N_REQ*WIDTH_MEM-1:0] i_addr_end,
    input  logic                       i_done,
    output logic                       o_start,
    output logic [10:0]                o_command,
    output logic [WIDTH_MEM-1:0]       o_addr_begin,
    output logic [WIDTH_MEM-1:0]       o_addr_end,
    output logic [N_REQ-1:0]           o_grant,
    output logic [N_REQ-1:0]           o_done,
    output logic                       o_ready,
    output logic                       o_err
);

    localparam int PWR_TACT = pwr_tact(CLOCK);
    localparam int PC_W     = $clog2(PWR_TACT + 1);
    localparam int WD_W     = $clog2(TIMEOUT + 1);
    localparam int PW       = $clog2(N_REQ);

    state_t               state;
    logic [PC_W-1:0]      pwr_cnt;
    logic [WD_W-1:0]      wd_cnt;
    logic [1:0]           init_idx;
    logic [PW-1:0]        rr_ptr;
    logic [N_REQ-1:0]     arb_grant;
    logic [PW-1:0]        arb_idx;
    logic [WIDTH_MEM-1:0] win_begin;
    logic [WIDTH_MEM-1:0] win_end;
    logic                 wd_expired;

    lcd_sequencer_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (i_req),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign win_begin = i_addr_begin[arb_idx*WIDTH_MEM +: WIDTH_MEM];
    assign win_end   = i_addr_end[arb_idx*WIDTH_MEM +: WIDTH_MEM];

    // Engine handshake: o_start is a one-cycle strobe on which the engine latches
    // o_command/o_addr_*; i_done is its one-cycle completion strobe, honoured only
    // while a transaction is outstanding (INIT_WAIT/RUN). A coincident i_done
    // beats the watchdog, which fires TIMEOUT cycles after o_start.
    assign wd_expired = ((state == ST_INIT_WAIT) || (state == ST_RUN)) && !i_done
                        && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_PWRUP;
            pwr_cnt      <= '0;
            wd_cnt       <= '0;
            init_idx     <= '0;
            rr_ptr       <= '0;
            o_start      <= 1'b0;
            o_command    <= '0;
            o_addr_begin <= '0;
            o_addr_end   <= '0;
            o_grant      <= '0;
            o_done       <= '0;
            o_ready      <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_start <= 1'b0;
            o_done  <= '0;
            o_err   <= 1'b0;
            case (state)
                ST_PWRUP: begin
                    if (pwr_cnt == PC_W'(PWR_TACT)) begin
                        pwr_cnt      <= '0;
                        o_command    <= init_cmd(init_idx);
                        o_addr_begin <= '0;
                        o_addr_end   <= '0;
                        o_start      <= 1'b1;
                        wd_cnt       <= '0;
                        state        <= ST_INIT_ISSUE;
                    end else begin
                        pwr_cnt <= pwr_cnt + 1'b1;
                    end
                end
                ST_INIT_ISSUE: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    state  <= ST_INIT_WAIT;
                end
                ST_INIT_WAIT: begin
                    if (i_done) begin
                        if (init_idx == INIT_LAST) begin
                            init_idx <= '0;
                            o_ready  <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            init_idx  <= init_idx + 2'd1;
                            o_command <= init_cmd(init_idx + 2'd1);
                            o_start   <= 1'b1;
                            wd_cnt    <= '0;
                            state     <= ST_INIT_ISSUE;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (|i_req) begin
                        o_grant      <= arb_grant;
                        o_addr_begin <= win_begin;
                        o_addr_end   <= win_end;
                        o_command    <= CMD_WRITE_DATA;
                        o_start      <= 1'b1;
                        wd_cnt       <= '0;
                        rr_ptr       <= (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
                        state        <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    state  <= ST_RUN;
                end
                ST_RUN: begin
                    if (i_done) begin
                        o_done  <= o_grant;
                        o_grant <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= ST_PWRUP;
            endcase

            // Stalled engine: drop the transaction silently and redo the whole
            // power-up/init; held requests are picked up again afterwards.
            if (wd_expired) begin
                o_err    <= 1'b1;
                o_ready  <= 1'b0;
                o_grant  <= '0;
                init_idx <= '0;
                pwr_cnt  <= '0;
                state    <= ST_PWRUP;
            end
        end
    end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer: table vectors, randomized transactions
// against a round-robin reference model, and hand-written init/watchdog/reset sequences.
module tb_lcd_sequencer;

    localparam int CLOCK     = 2614;
    localparam int WIDTH_MEM = 4;
    localparam int N_REQ     = 2;
    localparam int TIMEOUT   = 64;
    localparam int W         = N_REQ + 2 * WIDTH_MEM;

    logic                       i_clk = 1'b0;
    logic                       i_rst_n = 1'b0;
    logic [N_REQ-1:0]           i_req = '0;
    logic [N_REQ*WIDTH_MEM-1:0] i_addr_begin = '0;
    logic [N_REQ*WIDTH_MEM-1:0] i_addr_end = '0;
    logic                       i_done = 1'b0;
    logic                       o_start;
    logic [10:0]                o_command;
    logic [WIDTH_MEM-1:0]       o_addr_begin;
    logic [WIDTH_MEM-1:0]       o_addr_end;
    logic [N_REQ-1:0]           o_grant;
    logic [N_REQ-1:0]           o_done;
    logic                       o_ready;
    logic                       o_err;

    lcd_sequencer #(
        .CLOCK(CLOCK), .WIDTH_MEM(WIDTH_MEM), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req),
        .i_addr_begin(i_addr_begin), .i_addr_end(i_addr_end), .i_done(i_done),
        .o_start(o_start), .o_command(o_command), .o_addr_begin(o_addr_begin),
        .o_addr_end(o_addr_end), .o_grant(o_grant), .o_done(o_done),
        .o_ready(o_ready), .o_err(o_err)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL sim_time_limit: actual=expired required=finished");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int             n_tests = 0;
    int             n_fail = 0;
    int             pwr_wait;
    int             ptr_m = 0;
    logic [W-1:0]   exp_q[$];
    logic [10:0]    init_tbl [4] = '{11'h038, 11'h00C, 11'h001, 11'h006};

    typedef struct {
        logic [1:0] req;
        logic [3:0] b0, e0, b1, e1;
        logic [1:0] grant;
        logic [3:0] ab, ae;
        int         dly;
    } vec_t;
    vec_t tbl[8];

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_start();
        int c;
        c = 0;
        while (!o_start && c < 200) begin
            tick();
            c++;
        end
        check("start_seen", {31'd0, o_start}, 1);
    endtask

    task automatic drive_win(input logic [3:0] b0, e0, b1, e1);
        i_addr_begin = {b1, b0};
        i_addr_end   = {e1, e0};
    endtask

    function automatic int rr_pick(input logic [N_REQ-1:0] req, input int ptr);
        for (int i = 0; i < N_REQ; i++)
            if (req[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
        return -1;
    endfunction

    task automatic push_exp(input logic [N_REQ-1:0] req);
        int k;
        logic [N_REQ-1:0] oh;
        k = rr_pick(req, ptr_m);
        if (k >= 0) begin
            oh = '0;
            oh[k] = 1'b1;
            exp_q.push_back({oh, i_addr_begin[k*WIDTH_MEM +: WIDTH_MEM],
                             i_addr_end[k*WIDTH_MEM +: WIDTH_MEM]});
            ptr_m = (k + 1) % N_REQ;
        end
    endtask

    task automatic sb_start(output logic [W-1:0] expw);
        expw = '0;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: actual=start grant %0h expected=no start", o_grant);
        end else begin
            expw = exp_q.pop_front();
            check("grant_window", {22'd0, o_grant, o_addr_begin, o_addr_end}, {22'd0, expw});
            check("data_cmd", {21'd0, o_command}, 32'h200);
        end
    endtask

    task automatic finish_txn(input int dly, input logic [W-1:0] expw, input bit perturb, input bit drop);
        if (perturb)
            drive_win(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        if (drop) i_req = '0;
        for (int c = 0; c < dly; c++) begin
            tick();
            check("run_hold", {18'd0, o_done, o_err, o_ready, o_grant, o_addr_begin, o_addr_end},
                  {18'd0, 2'b00, 1'b0, 1'b1, expw});
        end
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        check("done_pulse", {30'd0, o_done}, {30'd0, expw[W-1 -: N_REQ]});
        check("grant_clear", {30'd0, o_grant}, 0);
        check("no_b2b_start", {31'd0, o_start}, 0);
    endtask

    task automatic run_init(input bit raise_req0);
        int busy;
        busy = 0;
        for (int s = 1; s <= pwr_wait; s++) begin
            tick();
            if (o_start || o_err || o_ready || (|o_grant) || (|o_done)) busy++;
        end
        check("pwrup_quiet", busy, 0);
        tick();
        check("pwrup_first_start", {31'd0, o_start}, 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) wait_start();
            check("init_cmd", {21'd0, o_command}, {21'd0, init_tbl[k]});
            check("init_state", {23'd0, o_ready, o_addr_begin, o_addr_end}, 0);
            tick(); tick(); tick();
            if (raise_req0 && k == 1) begin
                i_req = 2'b01;
                drive_win(4'd6, 4'd11, 4'd0, 4'd0);
            end
            i_done = 1'b1;
            tick();
            i_done = 1'b0;
        end
        check("init_ready", {31'd0, o_ready}, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] expw;
        int           gap;

        pwr_wait = int'($ceil(CLOCK * 0.015));
        if (pwr_wait < 1) pwr_wait = 1;

        tbl[0] = '{2'b11, 4'd0,  4'd5,  4'd8,  4'd13, 2'b01, 4'd0,  4'd5,  3};
        tbl[1] = '{2'b11, 4'd0,  4'd5,  4'd8,  4'd13, 2'b10, 4'd8,  4'd13, 3};
        tbl[2] = '{2'b11, 4'd0,  4'd5,  4'd8,  4'd13, 2'b01, 4'd0,  4'd5,  3};
        tbl[3] = '{2'b01, 4'd3,  4'd9,  4'd1,  4'd2,  2'b01, 4'd3,  4'd9,  1};
        tbl[4] = '{2'b10, 4'd0,  4'd0,  4'd7,  4'd2,  2'b10, 4'd7,  4'd2,  5};
        tbl[5] = '{2'b10, 4'd1,  4'd1,  4'd4,  4'd4,  2'b10, 4'd4,  4'd4,  2};
        tbl[6] = '{2'b01, 4'd12, 4'd3,  4'd5,  4'd5,  2'b01, 4'd12, 4'd3,  7};
        tbl[7] = '{2'b11, 4'd1,  4'd1,  4'd15, 4'd15, 2'b10, 4'd15, 4'd15, 3};

        // Reset values
        tick(); tick();
        check("rst_start", {31'd0, o_start}, 0);
        check("rst_cmd", {21'd0, o_command}, 0);
        check("rst_addr", {24'd0, o_addr_begin, o_addr_end}, 0);
        check("rst_grant", {30'd0, o_grant}, 0);
        check("rst_done", {30'd0, o_done}, 0);
        check("rst_ready_err", {30'd0, o_ready, o_err}, 0);
        i_rst_n = 1'b1;
        run_init(1'b0);

        // Table vectors: rr order, window latching, begin > end forwarding
        for (int i = 0; i < 8; i++) begin
            i_req = tbl[i].req;
            drive_win(tbl[i].b0, tbl[i].e0, tbl[i].b1, tbl[i].e1);
            exp_q.push_back({tbl[i].grant, tbl[i].ab, tbl[i].ae});
            for (int k = 0; k < N_REQ; k++)
                if (tbl[i].grant[k]) ptr_m = (k + 1) % N_REQ;
            wait_start();
            sb_start(expw);
            finish_txn(tbl[i].dly, expw, 1'b1, i == 4);
        end

        // Randomized transactions against the round-robin model
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_req = '0;
                gap = $urandom_range(1, 4);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("idle_no_start", {31'd0, o_start}, 0);
                end
            end
            i_req = 2'($urandom_range(1, 3));
            drive_win(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            push_exp(i_req);
            wait_start();
            sb_start(expw);
            finish_txn($urandom_range(1, 10), expw, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3) == 0);
        end

        // i_done while idle is ignored
        i_req = '0;
        tick();
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        check("idle_done_ignored", {28'd0, o_done, o_err, o_start}, 0);
        check("idle_ready_kept", {31'd0, o_ready}, 1);

        // Watchdog abort, re-init, pending request then served
        i_req = 2'b01;
        drive_win(4'd2, 4'd7, 4'd0, 4'd0);
        push_exp(i_req);
        wait_start();
        sb_start(expw);
        for (int c = 0; c < TIMEOUT - 1; c++) tick();
        check("wd_not_early", {30'd0, o_err, o_grant[0]}, 32'd1);
        tick();
        check("wd_err", {31'd0, o_err}, 1);
        check("wd_aborted", {27'd0, o_grant, o_done, o_ready}, 0);
        run_init(1'b0);
        push_exp(i_req);
        wait_start();
        sb_start(expw);
        finish_txn(3, expw, 1'b0, 1'b0);

        // i_done in the same cycle as watchdog expiry
        i_req = 2'b01;
        push_exp(i_req);
        wait_start();
        sb_start(expw);
        for (int c = 0; c < TIMEOUT - 1; c++) tick();
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        check("coinc_done", {30'd0, o_done}, 32'd1);
        check("coinc_no_err", {31'd0, o_err}, 0);
        check("coinc_ready", {31'd0, o_ready}, 1);

        // Asynchronous reset in RUN, then full power-up with a request raised during init
        i_req = 2'b10;
        drive_win(4'd0, 4'd0, 4'd9, 4'd14);
        push_exp(i_req);
        wait_start();
        sb_start(expw);
        tick(); tick();
        #2 i_rst_n = 1'b0;
        #1 check("async_rst_outputs",
                 {o_start, o_command, o_addr_begin, o_addr_end, o_grant, o_done, o_ready, o_err}, 0);
        i_req = '0;
        ptr_m = 0;
        exp_q.delete();
        tick(); tick();
        i_rst_n = 1'b1;
        run_init(1'b1);
        push_exp(i_req);
        wait_start();
        sb_start(expw);
        finish_txn(2, expw, 1'b0, 1'b0);
        i_req = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
